// File: rtl/pe_sequencer_pkg.sv
// Shared definitions for the PE sequencer and the PE controller:
// one-hot job modes, FSM encoding and the latched job descriptor.
package pe_sequencer_pkg;

  localparam logic [2:0] MOD_TYPE_A = 3'b001;
  localparam logic [2:0] MOD_TYPE_B = 3'b010;
  localparam logic [2:0] MOD_TYPE_C = 3'b100;

  localparam int CNT_W  = 5;  // load count, wide enough to hold 16
  localparam int ADDR_W = 4;  // weight buffer has 16 entries
  localparam int LEN_W  = 8;  // compute cycle count

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } pe_state_e;

  // Everything sampled with start that the rest of the job depends on.
  typedef struct packed {
    logic             bypass;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] nw;
  } pe_job_t;

  function automatic logic mod_is_valid(input logic [2:0] m);
    return (m == MOD_TYPE_A) || (m == MOD_TYPE_B) || (m == MOD_TYPE_C);
  endfunction

endpackage

// File: rtl/pe_sequencer_if.sv
// Command, weight stream, PE-side and status signals of the sequencer.
// master = host/DMA/PE environment, slave = the sequencer itself.
interface pe_sequencer_if #(parameter int DW = 16);
  logic          start;
  logic [2:0]    mod;
  logic          bypass_control;
  logic [7:0]    compute_len;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic          w_ready;
  logic          pe_ready;
  logic          irq_clr;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          enable;
  logic          bypass_signal;
  logic          busy;
  logic          mode_err;
  logic          interrupt;

  modport master (
    output start, mod, bypass_control, compute_len, w_valid, w_data,
           pe_ready, irq_clr,
    input  w_ready, wr_en, wr_addr, wr_data, enable, bypass_signal,
           busy, mode_err, interrupt
  );

  modport slave (
    input  start, mod, bypass_control, compute_len, w_valid, w_data,
           pe_ready, irq_clr,
    output w_ready, wr_en, wr_addr, wr_data, enable, bypass_signal,
           busy, mode_err, interrupt
  );
endinterface

// File: rtl/pe_seq_wload.sv
// Weight load path: valid/ready sink, address counter and a registered
// write port into the PE weight buffer. last_done flags the final beat.
module pe_seq_wload
  import pe_sequencer_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [CNT_W-1:0]  nw,
  input  logic              w_valid,
  input  logic [DW-1:0]     w_data,
  output logic              w_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic              last_done
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0]     wr_data_q, wr_data_d;
  logic              hs;

  assign w_ready   = go;
  assign hs        = go & w_valid;
  assign last_done = hs && (cnt_q == (nw - CNT_W'(1)));

  // Count accepted beats; the counter is cleared whenever we are not loading
  // so every job starts writing at address 0.
  always_comb begin
    cnt_d     = cnt_q;
    wr_en_d   = hs;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (!go) begin
      cnt_d = '0;
    end else if (hs) begin
      cnt_d     = cnt_q + CNT_W'(1);
      wr_addr_d = cnt_q[ADDR_W-1:0];
      wr_data_d = w_data;
    end
  end

  // Counter and write-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: rtl/pe_sequencer.sv
// PE job sequencer: IDLE -> LOAD (weights) -> COMPUTE (gated enable)
// -> DONE (sticky interrupt). Bypass jobs skip LOAD.
module pe_sequencer
  import pe_sequencer_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NW_A = 16,
  parameter int NW_B = 8,
  parameter int NW_C = 4
) (
  input  logic          clk,
  input  logic          rst,
  pe_sequencer_if.slave bus
);

  pe_state_e        state_q, state_d;
  pe_job_t          job_q, job_d;
  logic [LEN_W-1:0] ccnt_q, ccnt_d;
  logic             irq_q, irq_d;
  logic             merr_q, merr_d;
  logic             enable_c;
  logic             last_done;

  function automatic logic [CNT_W-1:0] nw_of(input logic [2:0] m);
    case (m)
      MOD_TYPE_A: nw_of = CNT_W'(NW_A);
      MOD_TYPE_B: nw_of = CNT_W'(NW_B);
      MOD_TYPE_C: nw_of = CNT_W'(NW_C);
      default:    nw_of = '0;
    endcase
  endfunction

  pe_seq_wload #(.DW(DW)) u_wload (
    .clk       (clk),
    .rst_n     (rst),
    .go        (state_q == ST_LOAD),
    .nw        (job_q.nw),
    .w_valid   (bus.w_valid),
    .w_data    (bus.w_data),
    .w_ready   (bus.w_ready),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .last_done (last_done)
  );

  // Next state, job latch, compute counter, enable and interrupt update.
  always_comb begin
    state_d  = state_q;
    job_d    = job_q;
    ccnt_d   = ccnt_q;
    merr_d   = 1'b0;
    irq_d    = irq_q & ~bus.irq_clr;
    enable_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ccnt_d = '0;
        if (bus.start) begin
          if (mod_is_valid(bus.mod)) begin
            job_d.bypass = bus.bypass_control;
            job_d.len    = bus.compute_len;
            job_d.nw     = nw_of(bus.mod);
            state_d      = bus.bypass_control ? ST_COMPUTE : ST_LOAD;
          end else begin
            merr_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (last_done) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        // Only a zero-length job can sit here with the count already at len;
        // otherwise we leave on the enable beat that reaches len.
        if (ccnt_q == job_q.len) begin
          state_d = ST_DONE;
        end else if (bus.pe_ready) begin
          enable_c = 1'b1;
          ccnt_d   = ccnt_q + LEN_W'(1);
          if (ccnt_q + LEN_W'(1) == job_q.len) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        irq_d   = 1'b1;  // set beats a simultaneous irq_clr
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and status registers; reset aborts any job without an interrupt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      job_q   <= '0;
      ccnt_q  <= '0;
      irq_q   <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      ccnt_q  <= ccnt_d;
      irq_q   <= irq_d;
      merr_q  <= merr_d;
    end
  end

  assign bus.enable        = enable_c;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.bypass_signal = job_q.bypass &
                             ((state_q == ST_COMPUTE) || (state_q == ST_DONE));
  assign bus.mode_err      = merr_q;
  assign bus.interrupt     = irq_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer: expected weight writes go into a
// scoreboard queue, a negedge monitor pops and compares every wr_en beat.
module tb_pe_sequencer;
  import pe_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pe_sequencer_if #(.DW(16)) bus ();

  pe_sequencer #(.DW(16), .NW_A(16), .NW_B(8), .NW_C(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t wq[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  en_total    = 0;
  int  busy_total  = 0;
  int  merr_total  = 0;
  int  byp_total   = 0;

  // Monitor: scoreboard compare of the write port plus activity counters.
  always @(negedge clk) begin
    wr_t e;
    if (bus.wr_en === 1'b1) begin
      vectors++;
      if (wq.size() == 0) begin
        miscompares++;
        $display("FAIL wr_unexpected: got addr %0d data %h, expected no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        e = wq.pop_front();
        if (e.addr !== bus.wr_addr || e.data !== bus.wr_data) begin
          miscompares++;
          $display("FAIL wr_port: got addr %0d data %h, expected addr %0d data %h",
                   bus.wr_addr, bus.wr_data, e.addr, e.data);
        end
      end
    end
    if (bus.enable === 1'b1)        en_total++;
    if (bus.busy === 1'b1)          busy_total++;
    if (bus.mode_err === 1'b1)      merr_total++;
    if (bus.bypass_signal === 1'b1) byp_total++;
    if (bus.w_ready === 1'b1 &&
        (bus.busy !== 1'b1 || bus.bypass_signal === 1'b1 || bus.enable === 1'b1)) begin
      miscompares++;
      $display("FAIL w_ready_scope: got w_ready 1 busy %b enable %b bypass %b, expected w_ready 0",
               bus.busy, bus.enable, bus.bypass_signal);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"},     bus.wr_en,         0);
    check({tag, "_w_ready"},   bus.w_ready,       0);
    check({tag, "_enable"},    bus.enable,        0);
    check({tag, "_busy"},      bus.busy,          0);
    check({tag, "_bypass"},    bus.bypass_signal, 0);
    check({tag, "_mode_err"},  bus.mode_err,      0);
    check({tag, "_interrupt"}, bus.interrupt,     0);
    check({tag, "_wr_addr"},   bus.wr_addr,       0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the following cycle.
  task automatic start_job(input logic [2:0] m, input logic byp, input logic [7:0] len);
    bus.start          = 1'b1;
    bus.mod            = m;
    bus.bypass_control = byp;
    bus.compute_len    = len;
    tick();
    bus.start          = 1'b0;
    bus.mod            = 3'b000;
    bus.bypass_control = 1'b0;
    bus.compute_len    = 8'd0;
  endtask

  task automatic expect_writes(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) wq.push_back('{addr: 4'(i), data: 16'(base + 16'(i))});
  endtask

  // Present n weights base, base+1, ...; toggle leaves a bubble every other cycle.
  task automatic feed(input int n, input logic [15:0] base, input bit toggle);
    int i = 0;
    int c = 0;
    while (i < n && c < 200) begin
      bus.w_valid = toggle ? (c % 2 == 0) : 1'b1;
      bus.w_data  = bus.w_valid ? 16'(base + 16'(i)) : 16'hdead;
      @(negedge clk);
      if (bus.w_valid && bus.w_ready === 1'b1) i++;
      tick();
      c++;
    end
    bus.w_valid = 1'b0;
    bus.w_data  = 16'h0;
    check("feed_beats", i, n);
  endtask

  task automatic wait_irq(input bit toggle_rdy);
    int c = 0;
    bit got = 0;
    while (c < 200) begin
      bus.pe_ready = toggle_rdy ? (c % 2 == 0) : 1'b1;
      @(negedge clk);
      if (bus.interrupt === 1'b1) begin
        got = 1;
        break;
      end
      tick();
      c++;
    end
    bus.pe_ready = 1'b1;
    check("irq_set", got, 1);
  endtask

  task automatic clear_irq();
    tick();
    bus.irq_clr = 1'b1;
    tick();
    bus.irq_clr = 1'b0;
    @(negedge clk);
    check("irq_clr", bus.interrupt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int e0, b0, p0, m0;
    bus.start = 0; bus.mod = 0; bus.bypass_control = 0; bus.compute_len = 0;
    bus.w_valid = 0; bus.w_data = 0; bus.pe_ready = 0; bus.irq_clr = 0;

    #12;
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b1;
    tick();

    // Mode A, full 16-weight load, 3 compute cycles.
    bus.pe_ready = 1'b1;
    e0 = en_total;
    expect_writes(16, 16'h1000);
    start_job(MOD_TYPE_A, 1'b0, 8'd3);
    feed(16, 16'h1000, 1'b0);
    wait_irq(1'b0);
    check("a_enable_cycles", en_total - e0, 3);
    check("a_busy_after", bus.busy, 0);
    check("a_writes_left", wq.size(), 0);
    clear_irq();

    // Mode C with a bubbly weight stream.
    tick();
    e0 = en_total;
    expect_writes(4, 16'h2000);
    start_job(MOD_TYPE_C, 1'b0, 8'd2);
    feed(4, 16'h2000, 1'b1);
    wait_irq(1'b0);
    check("c_enable_cycles", en_total - e0, 2);
    check("c_writes_left", wq.size(), 0);
    clear_irq();

    // Bypass mode B, pe_ready every other cycle: bypass for the whole job.
    tick();
    e0 = en_total; b0 = busy_total; p0 = byp_total;
    start_job(MOD_TYPE_B, 1'b1, 8'd5);
    wait_irq(1'b1);
    check("byp_enable_cycles", en_total - e0, 5);
    check("byp_bypass_cycles", byp_total - p0, busy_total - b0);
    check("byp_busy_cycles", busy_total - b0, 10);
    check("byp_bypass_after", bus.bypass_signal, 0);

    // New start while interrupt is still set: accepted, interrupt held.
    tick();
    e0 = en_total; b0 = busy_total;
    start_job(MOD_TYPE_C, 1'b1, 8'd2);
    repeat (4) tick();
    @(negedge clk);
    check("restart_busy_cycles", busy_total - b0, 3);
    check("restart_enable_cycles", en_total - e0, 2);
    check("restart_irq_held", bus.interrupt, 1);
    clear_irq();

    // Bypass, length 0: two busy cycles, irq_clr collides with the DONE set.
    tick();
    e0 = en_total; b0 = busy_total;
    start_job(MOD_TYPE_A, 1'b1, 8'd0);
    tick();
    bus.irq_clr = 1'b1;
    @(negedge clk);
    check("len0_busy_in_done", bus.busy, 1);
    tick();
    bus.irq_clr = 1'b0;
    @(negedge clk);
    check("set_wins_irq", bus.interrupt, 1);
    check("len0_busy_cycles", busy_total - b0, 2);
    check("len0_enable_cycles", en_total - e0, 0);
    clear_irq();

    // Non-one-hot mode: single error pulse, job not started.
    tick();
    m0 = merr_total; b0 = busy_total;
    start_job(3'b011, 1'b0, 8'd3);
    repeat (3) tick();
    @(negedge clk);
    check("merr_pulses", merr_total - m0, 1);
    check("merr_busy", busy_total - b0, 0);
    check("merr_irq", bus.interrupt, 0);

    // Reset in the middle of a load, after 7 accepted weights.
    tick();
    expect_writes(7, 16'h3000);
    start_job(MOD_TYPE_A, 1'b0, 8'd3);
    feed(7, 16'h3000, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check_zero("midload_rst");
    check("midload_writes_left", wq.size(), 0);
    @(posedge clk); #1 rst = 1'b1;
    tick();
    @(negedge clk);
    check("midload_no_irq", bus.interrupt, 0);

    // Fresh job after reset must start at address 0.
    tick();
    e0 = en_total;
    expect_writes(4, 16'h4000);
    start_job(MOD_TYPE_C, 1'b0, 8'd1);
    feed(4, 16'h4000, 1'b0);
    wait_irq(1'b0);
    check("post_rst_enable_cycles", en_total - e0, 1);
    check("post_rst_writes_left", wq.size(), 0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_sequencer.md
Name: pe_sequencer

Overview:
Sequences one processing element (PE) through a job: load weights, run compute, signal completion.
- Accepts a start command carrying a one-hot mode.
- Streams weights from an upstream valid/ready source into the PE weight buffer (16 entries, 4-bit address).
- Gates the PE compute enable for a programmed number of cycles, then raises a sticky interrupt.
- Sits between the host/DMA command path and a single PE.

Parameters:
DW, 16, weight data width.
NW_A, 16, weights loaded for mode A (3'b001); must be 1..16.
NW_B, 8, weights loaded for mode B (3'b010); must be 1..16.
NW_C, 4, weights loaded for mode C (3'b100); must be 1..16.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  job start pulse; sampled only in IDLE.
mod  in  3  one-hot mode; sampled with start.
bypass_control  in  1  skip weight load; sampled with start.
compute_len  in  8  compute cycles to run; sampled with start.
w_valid  in  1  upstream weight valid.
w_data  in  DW  upstream weight data.
w_ready  out  1  weight accept.
pe_ready  in  1  PE can accept a compute step this cycle.
irq_clr  in  1  clears interrupt.
wr_en  out  1  weight buffer write strobe.
wr_addr  out  4  weight buffer address.
wr_data  out  DW  weight buffer data.
enable  out  1  PE compute enable.
bypass_signal  out  1  PE bypass, held for the whole job.
busy  out  1  high in any state other than IDLE.
mode_err  out  1  one-cycle pulse: start arrived with a non-one-hot mod.
interrupt  out  1  sticky job-done flag.

Behaviour:
- Reset: every output is 0 and the FSM goes to IDLE. The async assert aborts any job in progress; no partial-job interrupt is raised.
- FSM states: IDLE, LOAD, COMPUTE, DONE.
- IDLE:
  - start with a valid one-hot mod: latch mod, bypass_control and compute_len; set NW from the mode.
  - Next state is COMPUTE if bypass_control=1, otherwise LOAD.
  - start with an invalid mod: pulse mode_err for 1 cycle next cycle; stay in IDLE.
- LOAD:
  - w_ready=1 combinationally while in LOAD.
  - A handshake (w_valid & w_ready) in cycle t gives wr_en=1, wr_addr=cnt, wr_data=w_data, all registered, in cycle t+1.
  - cnt starts at 0 and increments on each handshake.
  - The handshake with cnt==NW-1 moves the FSM to COMPUTE; w_ready drops the following cycle.
  - w_valid low: hold state and count with no timeout.
- COMPUTE:
  - enable = pe_ready (combinational AND with the state).
  - Cycle counter increments on each enable-high cycle.
  - When count reaches compute_len, go to DONE; enable is never high for more than compute_len cycles.
  - compute_len=0: go straight to DONE with enable never asserted.
  - bypass_signal=1 through COMPUTE and DONE when the job was started with bypass_control=1; cleared on return to IDLE.
- DONE: one cycle. Set interrupt, then go to IDLE. Total busy time for a bypass job with compute_len=0 is 2 cycles.
- interrupt:
  - Sticky; cleared by irq_clr.
  - Set and clear in the same cycle: set wins.
  - A new start while interrupt=1 is accepted; interrupt stays high.
- start outside IDLE is ignored, with no error.
- Counter widths: load count 5 bits; compute count 8 bits (no wrap, bounded by compute_len ≤ 255).

Decomposition:
- Shared package: one-hot mode constants MOD_TYPE_A/B/C (3'b001/3'b010/3'b100) and the FSM state encoding. The same constants are used by the PE controller.
- One natural sub-module, pe_seq_wload: the LOAD handshake, address counter and registered write port. It takes NW and a go input and returns a last_done signal.
- The FSM, compute counter and interrupt logic stay in pe_sequencer.

Test Plan:
- Mode A, no bypass, compute_len=3, w_valid always 1, pe_ready=1 -> 16 wr_en pulses with wr_addr 0..15, then enable high for exactly 3 cycles, then interrupt=1, busy=0.
- Mode C, w_valid toggled 1/0 -> exactly 4 writes at addresses 0..3, data matches stream order, w_ready never high outside LOAD.
- bypass_control=1, mode B, compute_len=5, pe_ready low every other cycle -> no wr_en, bypass_signal=1, exactly 5 enable cycles spread over about 10 cycles, then interrupt.
- mod=3'b011 with start -> mode_err pulses once, busy stays 0, no interrupt.
- irq_clr and a DONE-entry set in the same cycle -> interrupt remains 1; irq_clr on the next cycle -> 0.
- rst asserted mid-LOAD at cnt=7 -> all outputs 0 immediately; a new job afterwards starts writing at wr_addr 0.
